alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters SHALL be:
- CNT_W, 8, width of each per-requester completion counter.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock, all state on rising edge.
- rstN  in  1  asynchronous, active-low reset.
- reqValid  in  2  per-requester request valid; bit i belongs to requester i.
- reqReady  out  2  per-requester accept.
- reqInp1  in  16  operand 1; [7:0] is requester 0, [15:8] is requester 1.
- reqInp2  in  16  operand 2, packed the same way.
- reqShiftImm  in  6  immediate shift amount, 3 bits per requester.
- reqSelShiftAmt  in  2  1 selects the immediate shift amount, 0 selects inp2[2:0].
- reqOper  in  6  3-bit operation code per requester.
- reqSelOut  in  2  0 selects the ALU result, 1 selects the shifter result.
- respValid  out  1  result available.
- respReady  in  1  consumer accepts the result.
- respData  out  8  result.
- respId  out  1  requester that owns the result.
- respErr  out  1  illegal operation.
- busy  out  1  arbiter not in IDLE.
- doneCnt0, doneCnt1  out  CNT_W  completed-operation counts per requester.

Function
REQ-003 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-004 reqReady[i] SHALL be 1 only in IDLE and only for the granted requester; it SHALL be 0 in every other case.
REQ-005 Arbitration SHALL be round-robin:
- one valid requester is granted;
- if both are valid, the requester other than lastGrant is granted;
- lastGrant updates on each accept.
REQ-006 On accept (reqValid[i] and reqReady[i] at a clock edge):
- inp1, inp2, shiftImm, selShiftAmt, oper, selOut and id SHALL be captured into operand registers;
- the FSM SHALL go IDLE -> EXEC.
REQ-007 In EXEC the shared shifter/ALU datapath SHALL evaluate the operand registers combinationally. respData, respErr and respId SHALL be registered at the EXEC edge, and the FSM SHALL go EXEC -> RESP.
REQ-008 respValid SHALL equal 1 exactly in RESP, so latency from the accept edge to respValid high is 2 cycles.
REQ-009 In RESP, respData, respId and respErr SHALL hold stable until respReady=1 at an edge; then the FSM SHALL go RESP -> IDLE and doneCnt[respId] SHALL increment.
REQ-010 Maximum throughput SHALL be one operation per 3 cycles. No new request SHALL be accepted in EXEC or RESP.
REQ-011 Datapath semantics SHALL be as follows.
- selOut=0: 0 = inp1, 1 = add, 2 = sub (inp1-inp2), 3 = AND, 4 = OR, 5 = NOT inp1.
- selOut=1: 0 = no shift, 1 = arithmetic shift right, 2 = logical shift right, 3 = rotate right, 4 = logical shift left, 5 = rotate left.
- Shift amount is shiftImm if selShiftAmt=1, else inp2[2:0].
REQ-012 Arithmetic SHALL be 8-bit modulo 2^8, with no carry or overflow output.
REQ-013 oper 6 or 7 (either selOut) SHALL give respErr=1 and respData=8'h00. The response is still delivered and still counted.
REQ-014 Counters SHALL wrap from 2^CNT_W-1 to 0.
REQ-015 Deasserting reqValid while not granted SHALL have no effect. Deasserting it after accept SHALL NOT cancel the operation.
REQ-016 busy SHALL be 1 in EXEC and RESP.

Reset
REQ-017 When rstN=0, asynchronously and regardless of state, the block SHALL set:
- state to IDLE;
- reqReady, respValid, respErr and respId to 0;
- respData and the operand registers to 8'h00;
- busy to 0;
- doneCnt0 and doneCnt1 to 0;
- lastGrant to 1, so requester 0 wins the first tie.
REQ-018 Reset during EXEC or RESP SHALL discard the in-flight operation with no response and no count.

Structure
REQ-019 The shared package SHALL hold the state encoding and the oper codes (ALU and shift names).
REQ-020 The shifter/ALU datapath SHALL be a single instantiated sub-module, shifterAndALU, fed only from the operand registers.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Requester 0 only, inp1=80, inp2=20, oper=1, selOut=0 -> respData=100, respId=0, respValid high 2 cycles after accept, doneCnt0=1.
- Requester 1 only, inp1=80, shiftImm=2, selShiftAmt=1, oper=1, selOut=1 -> respData=20, respId=1.
- Both valid continuously, 4 ops -> grants 0,1,0,1 and reqReady never both high.
- respReady held 0 for 5 cycles in RESP -> respData, respId and respErr stable and no new accept; then respReady=1 -> IDLE next cycle.
- oper=6, selOut=0 -> respErr=1, respData=0, counter increments.
- rstN low in EXEC -> outputs at reset values immediately, no response, counters 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM state encoding and operation codes.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // ALU operations (selOut = 0)
  localparam logic [2:0] OP_ALU_PASS = 3'd0;
  localparam logic [2:0] OP_ALU_ADD  = 3'd1;
  localparam logic [2:0] OP_ALU_SUB  = 3'd2;
  localparam logic [2:0] OP_ALU_AND  = 3'd3;
  localparam logic [2:0] OP_ALU_OR   = 3'd4;
  localparam logic [2:0] OP_ALU_NOT  = 3'd5;

  // Shifter operations (selOut = 1)
  localparam logic [2:0] OP_SH_NONE = 3'd0;
  localparam logic [2:0] OP_SH_ASR  = 3'd1;
  localparam logic [2:0] OP_SH_LSR  = 3'd2;
  localparam logic [2:0] OP_SH_ROR  = 3'd3;
  localparam logic [2:0] OP_SH_LSL  = 3'd4;
  localparam logic [2:0] OP_SH_ROL  = 3'd5;

endpackage

// File: rtl/alu_arbiter_shifter_and_alu.sv
// Combinational shifter/ALU shared by both requesters; codes 6 and 7 are illegal and flag err.
module shifterAndALU
  import alu_arbiter_pkg::*;
(
  input  logic [7:0] inp1,
  input  logic [7:0] inp2,
  input  logic [2:0] shiftImm,
  input  logic       selShiftAmt,
  input  logic [2:0] oper,
  input  logic       selOut,
  output logic [7:0] result,
  output logic       err
);

  logic        [2:0]  shamt;
  logic signed [7:0]  inp1S;
  logic        [15:0] dbl;
  logic        [7:0]  rotR;
  logic        [7:0]  rotL;
  logic        [7:0]  aluRes;
  logic        [7:0]  shRes;

  assign shamt = selShiftAmt ? shiftImm : inp2[2:0];
  assign inp1S = $signed(inp1);
  // Rotates fall out of shifting the operand concatenated with itself.
  assign dbl   = {inp1, inp1};
  assign rotR  = 8'(dbl >> shamt);
  assign rotL  = 8'((dbl << shamt) >> 8);

  always_comb begin
    aluRes = 8'h00;
    case (oper)
      OP_ALU_PASS: aluRes = inp1;
      OP_ALU_ADD:  aluRes = inp1 + inp2;
      OP_ALU_SUB:  aluRes = inp1 - inp2;
      OP_ALU_AND:  aluRes = inp1 & inp2;
      OP_ALU_OR:   aluRes = inp1 | inp2;
      OP_ALU_NOT:  aluRes = ~inp1;
      default:     aluRes = 8'h00;
    endcase
  end

  always_comb begin
    shRes = 8'h00;
    case (oper)
      OP_SH_NONE: shRes = inp1;
      OP_SH_ASR:  shRes = inp1S >>> shamt;
      OP_SH_LSR:  shRes = inp1 >> shamt;
      OP_SH_ROR:  shRes = rotR;
      OP_SH_LSL:  shRes = inp1 << shamt;
      OP_SH_ROL:  shRes = rotL;
      default:    shRes = 8'h00;
    endcase
  end

  assign err    = (oper == 3'd6) || (oper == 3'd7);
  assign result = err ? 8'h00 : (selOut ? shRes : aluRes);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting two requesters access to one shifter/ALU; one op per 3 cycles.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [1:0]       reqValid,
  output logic [1:0]       reqReady,
  input  logic [15:0]      reqInp1,
  input  logic [15:0]      reqInp2,
  input  logic [5:0]       reqShiftImm,
  input  logic [1:0]       reqSelShiftAmt,
  input  logic [5:0]       reqOper,
  input  logic [1:0]       reqSelOut,
  output logic             respValid,
  input  logic             respReady,
  output logic [7:0]       respData,
  output logic             respId,
  output logic             respErr,
  output logic             busy,
  output logic [CNT_W-1:0] doneCnt0,
  output logic [CNT_W-1:0] doneCnt1
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e     state, nextState;
  logic       lastGrant;
  logic       grant;
  logic       accept;
  logic [7:0] aluResult;
  logic       aluErr;

  logic [7:0] inp1_p0, inp2_p0;
  logic [2:0] shiftImm_p0, oper_p0;
  logic       selShiftAmt_p0, selOut_p0, id_p0;

  // A tie goes to the requester that did not win last time.
  always_comb begin
    grant = 1'b0;
    if (&reqValid)                     grant = ~lastGrant;
    else if (reqValid[1] && !reqValid[0]) grant = 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= ST_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (accept)    nextState = ST_EXEC;
      ST_EXEC:                nextState = ST_RESP;
      ST_RESP: if (respReady) nextState = ST_IDLE;
      default:                nextState = ST_IDLE;
    endcase
  end

  // Ready is also masked by reset so it reads 0 the moment rstN falls.
  always_comb begin
    reqReady  = 2'b00;
    respValid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: if (rstN && reqValid[grant]) reqReady[grant] = 1'b1;
      ST_EXEC: busy = 1'b1;
      ST_RESP: begin
        busy      = 1'b1;
        respValid = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = |(reqValid & reqReady);

  // Stage p0: operand capture at accept
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      lastGrant      <= 1'b1;
      inp1_p0        <= 8'h00;
      inp2_p0        <= 8'h00;
      shiftImm_p0    <= 3'd0;
      selShiftAmt_p0 <= 1'b0;
      oper_p0        <= 3'd0;
      selOut_p0      <= 1'b0;
      id_p0          <= 1'b0;
    end else if (accept) begin
      lastGrant      <= grant;
      inp1_p0        <= grant ? reqInp1[15:8]    : reqInp1[7:0];
      inp2_p0        <= grant ? reqInp2[15:8]    : reqInp2[7:0];
      shiftImm_p0    <= grant ? reqShiftImm[5:3] : reqShiftImm[2:0];
      selShiftAmt_p0 <= reqSelShiftAmt[grant];
      oper_p0        <= grant ? reqOper[5:3]     : reqOper[2:0];
      selOut_p0      <= reqSelOut[grant];
      id_p0          <= grant;
    end
  end

  shifterAndALU u_datapath (
    .inp1        (inp1_p0),
    .inp2        (inp2_p0),
    .shiftImm    (shiftImm_p0),
    .selShiftAmt (selShiftAmt_p0),
    .oper        (oper_p0),
    .selOut      (selOut_p0),
    .result      (aluResult),
    .err         (aluErr)
  );

  // Stage p1: response registers, held through RESP
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      respData <= 8'h00;
      respErr  <= 1'b0;
      respId   <= 1'b0;
    end else if (state == ST_EXEC) begin
      respData <= aluResult;
      respErr  <= aluErr;
      respId   <= id_p0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      doneCnt0 <= '0;
      doneCnt1 <= '0;
    end else if (state == ST_RESP && respReady) begin
      if (respId) doneCnt1 <= doneCnt1 + CNT_ONE;
      else        doneCnt0 <= doneCnt0 + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter with an arithmetic reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [15:0] reqInp1, reqInp2;
  logic [5:0]  reqShiftImm, reqOper;
  logic [1:0]  reqSelShiftAmt, reqSelOut;
  logic        respValid, respReady;
  logic [7:0]  respData;
  logic        respId, respErr, busy;
  logic [7:0]  doneCnt0, doneCnt1;

  int nChecks = 0;
  int nErrors = 0;

  int fInp1[2], fInp2[2], fImm[2], fSel[2], fOp[2], fSo[2];
  int mLast;
  int cnt[2];
  int obsG;

  alu_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqReady(reqReady),
    .reqInp1(reqInp1), .reqInp2(reqInp2), .reqShiftImm(reqShiftImm),
    .reqSelShiftAmt(reqSelShiftAmt), .reqOper(reqOper), .reqSelOut(reqSelOut),
    .respValid(respValid), .respReady(respReady), .respData(respData),
    .respId(respId), .respErr(respErr), .busy(busy),
    .doneCnt0(doneCnt0), .doneCnt1(doneCnt1)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result straight from the operation table using integer arithmetic.
  function automatic int model(input int a, input int b, input int imm, input int sel,
                               input int op, input int so, output bit err);
    int amt;
    amt = sel ? imm : (b % 8);
    err = (op >= 6);
    if (err) return 0;
    if (so == 0) begin
      case (op)
        0: return a;
        1: return (a + b) % 256;
        2: return (a - b + 256) % 256;
        3: return a & b;
        4: return a | b;
        default: return 255 - a;
      endcase
    end
    case (op)
      0: return a;
      1: return (a >> amt) | ((a >= 128) ? ((255 << (8 - amt)) & 255) : 0);
      2: return a >> amt;
      3: return ((a >> amt) | (a << (8 - amt))) & 255;
      4: return (a << amt) & 255;
      default: return ((a << amt) | (a >> (8 - amt))) & 255;
    endcase
  endfunction

  task automatic drive_fields;
    for (int r = 0; r < 2; r++) begin
      reqInp1[r*8 +: 8]     = 8'(fInp1[r]);
      reqInp2[r*8 +: 8]     = 8'(fInp2[r]);
      reqShiftImm[r*3 +: 3] = 3'(fImm[r]);
      reqSelShiftAmt[r]     = 1'(fSel[r]);
      reqOper[r*3 +: 3]     = 3'(fOp[r]);
      reqSelOut[r]          = 1'(fSo[r]);
    end
  endtask

  task automatic rand_fields(input int r);
    fInp1[r] = $urandom_range(0, 255);
    fInp2[r] = $urandom_range(0, 255);
    fImm[r]  = $urandom_range(0, 7);
    fSel[r]  = $urandom_range(0, 1);
    fOp[r]   = $urandom_range(0, 7);
    fSo[r]   = $urandom_range(0, 1);
  endtask

  task automatic set_fields(input int r, input int a, input int b, input int imm,
                            input int sel, input int op, input int so);
    fInp1[r] = a; fInp2[r] = b; fImm[r] = imm; fSel[r] = sel; fOp[r] = op; fSo[r] = so;
  endtask

  // One complete transaction: accept, EXEC, RESP held for 'hold' extra cycles, then drain.
  task automatic op_full(input logic [1:0] vmask, input int hold);
    int g, e;
    bit ee;
    logic [1:0] expRdy;
    drive_fields();
    reqValid = vmask;
    #1;
    g = (vmask == 2'b11) ? (mLast ? 0 : 1) : (vmask[0] ? 0 : 1);
    expRdy = (g == 0) ? 2'b01 : 2'b10;
    e = model(fInp1[g], fInp2[g], fImm[g], fSel[g], fOp[g], fSo[g], ee);
    obsG = reqReady[1] ? 1 : 0;
    check("ready_idle", reqReady, expRdy);
    tick;
    mLast = g;
    check("busy_exec", busy, 1);
    check("valid_exec", respValid, 0);
    check("ready_exec", reqReady, 0);
    rand_fields(g);
    drive_fields();
    tick;
    check("valid_resp", respValid, 1);
    check("data", respData, e);
    check("id", respId, g);
    check("err", respErr, ee);
    for (int h = 0; h < hold; h++) begin
      tick;
      check("hold_valid", respValid, 1);
      check("hold_data", respData, e);
      check("hold_id", respId, g);
      check("hold_err", respErr, ee);
      check("hold_ready", reqReady, 0);
    end
    respReady = 1'b1;
    tick;
    respReady = 1'b0;
    cnt[g] = (cnt[g] + 1) % 256;
    check("idle_busy", busy, 0);
    check("idle_valid", respValid, 0);
    check("cnt0", doneCnt0, cnt[0]);
    check("cnt1", doneCnt1, cnt[1]);
  endtask

  task automatic check_reset_outputs;
    check("rst_ready", reqReady, 0);
    check("rst_valid", respValid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", respData, 0);
    check("rst_id", respId, 0);
    check("rst_err", respErr, 0);
    check("rst_cnt0", doneCnt0, 0);
    check("rst_cnt1", doneCnt1, 0);
  endtask

  initial begin
    rstN = 1'b0; reqValid = 2'b00; respReady = 1'b0;
    reqInp1 = '0; reqInp2 = '0; reqShiftImm = '0; reqSelShiftAmt = '0;
    reqOper = '0; reqSelOut = '0;
    mLast = 1; cnt[0] = 0; cnt[1] = 0;
    for (int r = 0; r < 2; r++) set_fields(r, 0, 0, 0, 0, 0, 0);
    tick; tick;
    check_reset_outputs();
    rstN = 1'b1;
    tick;

    // Requester 0 alone: 80 + 20
    set_fields(0, 80, 20, 0, 0, 1, 0);
    op_full(2'b01, 0);
    check("s1_cnt0", doneCnt0, 1);
    reqValid = 2'b00;

    // Requester 1 alone: 80 >>> 2 via immediate
    set_fields(1, 80, 0, 2, 1, 1, 1);
    op_full(2'b10, 0);
    check("s2_grant", obsG, 1);

    // Both valid: alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      rand_fields(0); rand_fields(1);
      op_full(2'b11, 0);
      check("rr_grant", obsG, k % 2);
    end

    // Backpressure for 5 cycles with both still requesting
    rand_fields(0); rand_fields(1);
    op_full(2'b11, 5);

    // Illegal operation still responds and counts
    reqValid = 2'b00;
    set_fields(0, 8'hAA, 8'h55, 0, 0, 6, 0);
    op_full(2'b01, 0);

    // Reset during EXEC discards the operation
    reqValid = 2'b00;
    tick;
    set_fields(0, 10, 20, 0, 0, 1, 0);
    drive_fields();
    reqValid = 2'b01;
    tick;
    check("s6_busy", busy, 1);
    #1 rstN = 1'b0;
    #1;
    check_reset_outputs();
    #1 rstN = 1'b1;
    reqValid = 2'b00;
    mLast = 1; cnt[0] = 0; cnt[1] = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("s6_novalid", respValid, 0);
      check("s6_cnt0", doneCnt0, 0);
    end
    rand_fields(0); rand_fields(1);
    op_full(2'b11, 0);
    check("s6_tie", obsG, 0);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      logic [1:0] vm;
      vm = 2'($urandom_range(1, 3));
      rand_fields(0); rand_fields(1);
      op_full(vm, $urandom_range(0, 2));
    end

    // Counter wrap on requester 0
    for (int k = 0; k < 257; k++) begin
      rand_fields(0);
      op_full(2'b01, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
